// File: rtl/rejunity_fp4_mul_i8.sv
// ---------------------------------------------------------------------------
// rejunity_fp4_mul_i8
//
// Outer-product matrix-multiply tile for a TinyTapeout slot. FP4 (e2m1)
// weights and signed int8 activations stream in one element per clock.
// Every COMPUTE_SLICES cycles the two vectors are complete and their outer
// product is added into an N x N array of 16-bit signed accumulators. On the
// same edge the previous accumulator contents are halved, saturated to int8
// and loaded into an output buffer that shifts out on uo_out, one entry per
// cycle, in row-major order (row = weight index, column = activation index).
//
// FP4 values are kept doubled (0.5 -> 1) so the datapath stays integer; the
// final >>>1 in the readout removes that scaling.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_n    : synchronous active-low reset
//   ena      : slot-selected flag, unused
//   ui_in    : [3:0] FP4 weight code, [4] zero_acc, [7:5] unused
//   uio_in   : signed int8 activation
//   uo_out   : serial saturated int8 result stream
//   uio_out  : constant 0
//   uio_oe   : constant 0 (all bidirectional pins are inputs)
// ---------------------------------------------------------------------------
module rejunity_fp4_mul_i8 #(
  parameter int COMPUTE_SLICES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int N  = COMPUTE_SLICES;
  localparam int NN = N * N;
  localparam int CW = $clog2(N);

  // Doubled FP4 magnitude; bit 3 negates, and -0 naturally collapses to 0.
  function automatic logic signed [4:0] fp4_decode(input logic [3:0] code);
    logic signed [4:0] mag;
    case (code[2:0])
      3'd0:    mag = 5'sd0;
      3'd1:    mag = 5'sd1;
      3'd2:    mag = 5'sd2;
      3'd3:    mag = 5'sd3;
      3'd4:    mag = 5'sd4;
      3'd5:    mag = 5'sd6;
      3'd6:    mag = 5'sd8;
      default: mag = 5'sd12;
    endcase
    return code[3] ? -mag : mag;
  endfunction

  // Undo the x2 weight scaling (floor), then clamp to the int8 range.
  function automatic logic [7:0] sat8(input logic signed [15:0] acc);
    logic signed [15:0] half;
    half = acc >>> 1;
    if (half > 16'sd127)       return 8'h7f;
    else if (half < -16'sd128) return 8'h80;
    else                       return half[7:0];
  endfunction

  // Elements 0..N-2 of the current step; element N-1 is used live.
  logic signed [4:0]  w_q   [N-1];
  logic signed [7:0]  a_q   [N-1];
  logic signed [15:0] acc_q [N][N];
  logic        [7:0]  buf_q [NN];
  logic [CW-1:0]      cnt_q, cnt_d;

  logic signed [4:0]  w_live;
  logic signed [7:0]  a_live;
  logic signed [4:0]  w_vec [N];
  logic signed [7:0]  a_vec [N];
  logic signed [15:0] acc_d [N][N];
  logic signed [11:0] prod;
  logic               last;
  logic               zero_acc;

  assign last     = (cnt_q == CW'(N - 1));
  assign zero_acc = ui_in[4];

  // NOTE: every combinational output is assigned before any conditional
  // logic, so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_live = fp4_decode(ui_in[3:0]);
    a_live = $signed(uio_in);
    cnt_d  = last ? '0 : cnt_q + CW'(1);
    prod   = '0;
    for (int k = 0; k < N - 1; k++) begin
      w_vec[k] = w_q[k];
      a_vec[k] = a_q[k];
    end
    w_vec[N-1] = w_live;
    a_vec[N-1] = a_live;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        // |12 x -128| = 1536 fits a 12-bit signed product.
        prod        = 12'(w_vec[i]) * 12'(a_vec[j]);
        acc_d[i][j] = zero_acc ? 16'(prod) : acc_q[i][j] + 16'(prod);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the buffer load therefore sees the accumulators
  // before this step's update, which is the intended readout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int k = 0; k < N - 1; k++) begin
        w_q[k] <= '0;
        a_q[k] <= '0;
      end
      // NOTE: the accumulator array and output buffer are cleared on reset
      // because a reset must discard all earlier results; this costs reset
      // fan-out to every bit, which is accepted for this small array.
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= '0;
        end
      end
      for (int k = 0; k < NN; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < N - 1; k++) begin
        if (cnt_q == CW'(k)) begin
          w_q[k] <= w_live;
          a_q[k] <= a_live;
        end
      end
      if (last) begin
        // Load overrides the shift on the step-completion edge.
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            buf_q[i*N + j] <= sat8(acc_q[i][j]);
            acc_q[i][j]    <= acc_d[i][j];
          end
        end
      end else begin
        for (int k = 0; k < NN - 1; k++) begin
          buf_q[k] <= buf_q[k+1];
        end
        buf_q[NN-1] <= '0;
      end
    end
  end

  assign uo_out  = buf_q[0];
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:5]};

endmodule

// File: tb/tb_rejunity_fp4_mul_i8.sv
// ---------------------------------------------------------------------------
// Testbench for rejunity_fp4_mul_i8 (N = 4).
// A cycle-level reference model predicts uo_out for every driven cycle and
// pushes it into a queue; a monitor pops and compares one entry after each
// rising edge. Directed readouts additionally compare the result streams
// against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_rejunity_fp4_mul_i8;

  localparam int N  = 4;
  localparam int NN = N * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];

  // Reference model state
  int                 m_cnt = 0;
  int                 m_w   [N];
  int                 m_a   [N];
  logic signed [15:0] m_acc [N][N];
  int                 m_buf [NN];

  rejunity_fp4_mul_i8 #(.COMPUTE_SLICES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h) at %0t",
               tag, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  function automatic int dec_model(input logic [3:0] code);
    int tab [8];
    int v;
    tab = '{0, 1, 2, 3, 4, 6, 8, 12};
    v = tab[code[2:0]];
    return code[3] ? -v : v;
  endfunction

  function automatic int sat_model(input int v);
    int s;
    s = v >>> 1;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic model_cycle(input logic rst, input logic [3:0] wc,
                             input logic [7:0] act, input logic zacc);
    int p;
    if (!rst) begin
      m_cnt = 0;
      for (int i = 0; i < N; i++) begin
        m_w[i] = 0;
        m_a[i] = 0;
        for (int j = 0; j < N; j++) m_acc[i][j] = '0;
      end
      for (int k = 0; k < NN; k++) m_buf[k] = 0;
    end else begin
      m_w[m_cnt] = dec_model(wc);
      m_a[m_cnt] = int'($signed(act));
      if (m_cnt == N - 1) begin
        for (int k = 0; k < NN; k++) m_buf[k] = sat_model(int'(m_acc[k / N][k % N]));
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            p = m_w[i] * m_a[j];
            m_acc[i][j] = zacc ? 16'(p) : m_acc[i][j] + 16'(p);
          end
        end
        m_cnt = 0;
      end else begin
        for (int k = 0; k < NN - 1; k++) m_buf[k] = m_buf[k+1];
        m_buf[NN-1] = 0;
        m_cnt++;
      end
    end
  endtask

  // One clock of stimulus; the model's prediction is queued for the monitor.
  task automatic drive_cycle(input logic [3:0] wc, input logic [7:0] act,
                             input logic zacc, input logic rst);
    @(negedge clk);
    rst_n  = rst;
    ui_in  = {3'($urandom_range(7, 0)), zacc, wc};
    uio_in = act;
    model_cycle(rst, wc, act, zacc);
    exp_q.push_back(8'(m_buf[0]));
  endtask

  // Full step with one weight code on all lanes. zacc applies on the last
  // element; z_early is driven on the other elements, where it must be ignored.
  task automatic run_step(input logic [3:0] wc, input int a0, input int a1,
                          input int a2, input int a3, input logic zacc,
                          input logic z_early);
    int av [N];
    av = '{a0, a1, a2, a3};
    for (int k = 0; k < N; k++)
      drive_cycle(wc, 8'(av[k]), (k == N - 1) ? zacc : z_early, 1'b1);
  endtask

  // Checks the first four stream entries after a load, driving a zero step.
  task automatic expect_stream(input string tag, input int v0, input int v1,
                               input int v2, input int v3);
    int ev [N];
    ev = '{v0, v1, v2, v3};
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #2;
      check(tag, uo_out, 8'(ev[k]));
      drive_cycle(4'h0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("stream", uo_out, exp_q.pop_front());
  end

  initial begin
    // Reset held for two edges
    drive_cycle(4'h0, 8'h00, 1'b0, 1'b0);
    drive_cycle(4'h0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    run_step(4'h0, 0, 0, 0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    check("zero_step", uo_out, 8'h00);

    // Basic product: weight 1.0 times 1..4
    run_step(4'h2, 1, 2, 3, 4, 1'b1, 1'b0);
    run_step(4'h0, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_stream("basic", 1, 2, 3, 4);

    // Accumulate twice; zero_acc high on early elements must be ignored
    run_step(4'h2, 1, 2, 3, 4, 1'b1, 1'b0);
    run_step(4'h2, 1, 2, 3, 4, 1'b0, 1'b1);
    run_step(4'h0, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_stream("accum", 2, 4, 6, 8);

    // Negative half weight, floor on shift: -1 * 5 = -5 -> -3
    run_step(4'h9, 5, 0, 0, 0, 1'b1, 1'b0);
    run_step(4'h0, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_stream("neg_floor", -3, 0, 0, 0);

    // Negative zero weight
    run_step(4'h8, 5, 5, 5, 5, 1'b1, 1'b0);
    run_step(4'h0, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_stream("neg_zero", 0, 0, 0, 0);

    // Saturation: 12*127 = 1524 -> 127, 12*-128 = -1536 -> -128
    run_step(4'h7, 127, -128, 0, 0, 1'b1, 1'b0);
    run_step(4'h0, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_stream("saturate", 127, -128, 0, 0);

    // Reset mid-step: partial elements and prior accumulators are discarded
    drive_cycle(4'h2, 8'd7, 1'b0, 1'b1);
    drive_cycle(4'h2, 8'd7, 1'b0, 1'b1);
    drive_cycle(4'h0, 8'h00, 1'b0, 1'b0);
    run_step(4'h2, 10, 20, 30, 40, 1'b1, 1'b0);
    expect_stream("mid_rst_prior", 0, 0, 0, 0);
    expect_stream("mid_rst_result", 10, 20, 30, 40);

    // Drain the scoreboard
    drive_cycle(4'h0, 8'h00, 1'b0, 1'b1);
    drive_cycle(4'h0, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    check("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
